mul_share_arb: RTL and testbench

Round-robin scheduler that shares one external 16x16 signed pipelined multiplier among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the multiplier. It tracks each issued operation through the fixed multiplier latency with a tag shadow pipeline, then returns the 32-bit product with the requester ID through a credit-protected response FIFO. It sits between the compute clients and the multiplier datapath, and it is the only block that drives the multiplier operand inputs.

---
 rtl/mul_share_arb_if.sv | 25 ++
 rtl/mul_share_arb.sv | 129 ++++++++++++
 tb/tb_mul_share_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester, multiplier and response bundle of mul_share_arb.
interface mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [15:0]           mul_a;
    logic [15:0]           mul_b;
    logic [31:0]           mul_c;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_c;
    logic [ID_W-1:0]       resp_id;
    modport master (
        output req_valid, req_a, req_b, mul_c, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, resp_c, resp_id
    );
    modport slave (
        input  req_valid, req_a, req_b, mul_c, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, resp_c, resp_id
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one pipelined 16x16 signed multiplier with a credit-protected response FIFO.
// Define MUL_SHARE_ARB_PERF_EN to add the perf_issue_cnt/perf_stall_cnt saturating counters.
module mul_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MUL_LAT   = 3,
    parameter int RSP_DEPTH = 8,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
`ifdef MUL_SHARE_ARB_PERF_EN
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    mul_share_arb_if.slave bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    off;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      sum;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic               credit_ok;
    logic               issue;
    logic               push;
    logic               pop;
    logic               full;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_cnt;
    logic [CW:0]        used;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [MUL_LAT-1:0] sh_vld;
    logic [ID_W-1:0]    sh_id [MUL_LAT];
    logic [31:0]        mem_c [RSP_DEPTH];
    logic [ID_W-1:0]    mem_id [RSP_DEPTH];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the next requester in round-robin order.
    assign rot   = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    assign found = |bus.req_valid;

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = ID_W'(k);
        end
    end

    assign sum = (ID_W+1)'(rr_ptr) + (ID_W+1)'(off);
    assign win = ID_W'((sum >= (ID_W+1)'(NUM_REQ)) ? sum - (ID_W+1)'(NUM_REQ) : sum);

    // Credits cover both in-flight products and buffered responses, so the FIFO can never overflow.
    assign used      = (CW+1)'(inflight) + (CW+1)'(fifo_cnt);
    assign credit_ok = used < (CW+1)'(RSP_DEPTH);
    assign issue     = found && credit_ok && !rst;

    always_comb begin
        bus.req_ready = '0;
        bus.mul_a     = '0;
        bus.mul_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (issue && win == ID_W'(k)) begin
                bus.req_ready[k] = 1'b1;
                bus.mul_a        = bus.req_a[16*k +: 16];
                bus.mul_b        = bus.req_b[16*k +: 16];
            end
        end
    end

    assign push           = sh_vld[MUL_LAT-1];
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign full           = fifo_cnt == CW'(RSP_DEPTH);
    assign bus.resp_valid = fifo_cnt != '0;
    assign bus.resp_c     = mem_c[rd_ptr];
    assign bus.resp_id    = mem_id[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            sh_vld   <= '0;
            for (int s = 0; s < MUL_LAT; s++) sh_id[s] <= '0;
            for (int e = 0; e < RSP_DEPTH; e++) begin
                mem_c[e]  <= '0;
                mem_id[e] <= '0;
            end
        end else begin
            if (issue) rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            inflight <= inflight + CW'(issue) - CW'(push);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) begin
                mem_c[wr_ptr]  <= bus.mul_c;
                mem_id[wr_ptr] <= sh_id[MUL_LAT-1];
                wr_ptr         <= wrap_inc(wr_ptr);
            end
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            sh_vld[0] <= issue;
            sh_id[0]  <= win;
            for (int s = 1; s < MUL_LAT; s++) begin
                sh_vld[s] <= sh_vld[s-1];
                sh_id[s]  <= sh_id[s-1];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

`ifdef MUL_SHARE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_issue_cnt != '1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (found && !credit_ok && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed scoreboard bench for mul_share_arb with a 3-stage multiplier model.
module tb_mul_share_arb;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [33:0] q[$];
    logic [33:0] exp_r;
    logic [31:0] p [3];
    logic [31:0] rr_prod [4];

    always #5 clk = ~clk;

    mul_share_arb_if #(.NUM_REQ(N), .ID_W(2)) bus();

`ifdef MUL_SHARE_ARB_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    mul_share_arb dut (
        .clk(clk),
        .rst(rst),
`ifdef MUL_SHARE_ARB_PERF_EN
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus(bus)
    );

    // Environment multiplier: product appears on mul_c three cycles after the operands.
    initial for (int s = 0; s < 3; s++) p[s] = '0;
    always @(posedge clk) begin
        p[0] <= {{16{bus.mul_a[15]}}, bus.mul_a} * {{16{bus.mul_b[15]}}, bus.mul_b};
        p[1] <= p[0];
        p[2] <= p[1];
    end
    assign bus.mul_c = p[2];

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got id=%0d c=%h want none", bus.resp_id, bus.resp_c);
            end else begin
                exp_r = q.pop_front();
                if ({bus.resp_id, bus.resp_c} !== exp_r) begin
                    bad++;
                    $display("FAIL resp: got id=%0d c=%h want id=%0d c=%h",
                             bus.resp_id, bus.resp_c, exp_r[33:32], exp_r[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b, input logic [31:0] want);
        int n = 0;
        bus.req_valid[i]       = 1'b1;
        bus.req_a[16*i +: 16]  = a;
        bus.req_b[16*i +: 16]  = b;
        #1;
        while (!bus.req_ready[i] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept on req %0d", i);
        end else q.push_back({2'(i), want});
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.resp_valid) && n < 60) begin
            tick();
            n++;
        end
        chk("drain", {63'(q.size()), bus.resp_valid}, 64'd0);
    endtask

    task automatic latency(input string nm);
        int lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk(nm, 64'(lat + 1), 64'd4);
    endtask

    initial begin
        int nis;
        rr_prod = '{32'hFFFF_FF9C, 32'hFFFF_FE70, 32'hFFFF_FC7C, 32'hFFFF_F9C0};
        bus.resp_ready = 1'b0;
        bus.req_valid  = '1;
        bus.req_a      = {4{16'h1234}};
        bus.req_b      = {4{16'h0005}};
        repeat (3) tick();
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_mul_b", bus.mul_b, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_c", bus.resp_c, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        bus.req_valid  = '0;
        rst            = 1'b0;
        bus.resp_ready = 1'b1;
        tick();

        // Single request from requester 2: -3 * 7.
        bus.req_valid[2]  = 1'b1;
        bus.req_a[47:32]  = 16'hFFFD;
        bus.req_b[47:32]  = 16'h0007;
        #1;
        chk("single_ready", bus.req_ready, 4'b0100);
        chk("single_mul_a", bus.mul_a, 16'hFFFD);
        chk("single_mul_b", bus.mul_b, 16'h0007);
        q.push_back({2'd2, 32'hFFFF_FFEB});
        tick();
        bus.req_valid[2] = 1'b0;
        latency("single_latency");
        drain();

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // All requesters valid: grants rotate 0,1,2,3 with one issue per cycle.
        bus.req_a     = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.req_b     = {16'hFE70, 16'hFED4, 16'hFF38, 16'hFF9C};
        bus.req_valid = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant%0d", k), bus.req_ready, 64'd1 << (k % 4));
            q.push_back({2'(k % 4), rr_prod[k % 4]});
            tick();
        end
        bus.req_valid = '0;
        drain();

        // Consumer stalled: requester 0 fills the credit pool, then is blocked.
        bus.resp_ready   = 1'b0;
        bus.req_valid[0] = 1'b1;
        nis = 0;
        for (int c = 0; c < 14; c++) begin
            bus.req_a[15:0] = 16'(nis + 1);
            bus.req_b[15:0] = 16'hFFFE;
            #1;
            if (bus.req_ready[0]) begin
                q.push_back({2'd0, 32'(-2 * (nis + 1))});
                nis++;
            end
            tick();
        end
        chk("stream_issues", 64'(nis), 64'd8);
        chk("stream_blocked", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        #1;
        chk("pop_cycle_ready", bus.req_ready, 0);
        tick();
        chk("resume_ready", bus.req_ready, 4'b0001);
        q.push_back({2'd0, 32'hFFFF_FFEE});
        tick();
        bus.req_valid[0] = 1'b0;
        drain();

        // Extreme operands.
        send(1, 16'h8000, 16'h8000, 32'h4000_0000);
        send(3, 16'h8000, 16'h7FFF, 32'hC000_8000);
        send(0, 16'h0000, 16'hFFFF, 32'h0000_0000);
        drain();

        // Reset with three products in flight and two buffered: all are discarded.
        bus.resp_ready   = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_a[15:0]  = 16'd11;
        bus.req_b[15:0]  = 16'd13;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rst_setup%0d", c), bus.req_ready, 4'b0001);
            tick();
        end
        bus.req_valid = '0;
        rst           = 1'b1;
        tick();
        rst            = 1'b0;
        bus.resp_ready = 1'b1;
        bus.req_valid  = '1;
        bus.req_a      = {16'd9, 16'd9, 16'd9, 16'd6};
        bus.req_b      = {16'd9, 16'd9, 16'd9, 16'd7};
        #1;
        chk("post_rst_grant", bus.req_ready, 4'b0001);
        q.push_back({2'd0, 32'd42});
        tick();
        bus.req_valid = '0;
        latency("post_rst_latency");
        drain();

`ifdef MUL_SHARE_ARB_PERF_EN
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        bus.resp_ready   = 1'b0;
        bus.req_valid[1] = 1'b1;
        bus.req_a[31:16] = 16'd3;
        bus.req_b[31:16] = 16'd5;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (bus.req_ready[1]) q.push_back({2'd1, 32'd15});
            tick();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        drain();
        send(2, 16'd2, 16'd2, 32'd4);
        send(2, 16'd2, 16'd3, 32'd6);
        chk("perf_issue_cnt", perf_issue_cnt, 10);
        chk("perf_stall_cnt", perf_stall_cnt, 5);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
